// File: rtl/video_capture_pkg.sv
// video_capture_pkg: shared constants and types for the video capture block
// Holds register offsets, CTRL/STATUS bit positions, the FSM state encoding,
// the CRC-16-CCITT constants and a per-byte CRC helper.
package video_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_FCNT   = 2'd2;
    localparam logic [1:0] REG_CRC    = 2'd3;

    localparam int CTRL_ARM  = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_CLR  = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_ERR_LINE = 2;
    localparam int ST_ERR_OVR  = 3;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // MSB-first CRC-16-CCITT update over one byte
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/video_capture_crc.sv
// video_capture_crc: one-pixel-per-cycle CRC-16-CCITT accumulator
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (register resets to 0)
//   clr        : load CRC_INIT (start of a frame)
//   en         : fold data into the CRC, low byte first
//   data       : pixel value
//   crc        : current CRC value
module video_capture_crc
    import video_capture_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] data,
    output logic [15:0]      crc
);

    localparam int NB = (PIX_W + 7) / 8;

    logic [NB*8-1:0] padded;
    logic [15:0]     crc_nxt;

    always_comb begin
        padded = '0;
        padded[PIX_W-1:0] = data;
        crc_nxt = crc;
        for (int i = 0; i < NB; i++)
            crc_nxt = crc16_byte(crc_nxt, padded[i*8 +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= '0;
        else if (clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc_nxt;
    end

endmodule

// File: rtl/video_capture.sv
// video_capture: writes an incoming DE/HSYNC/VSYNC pixel stream into VRAM
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   vid_de/hsync/vsync    : video timing (hsync is not used for addressing)
//   vid_data              : pixel, valid with vid_de
//   vram_we/addr/wdata    : VRAM write port, two cycles after the pixel input
//   sel, addr, we, qin    : local bus register access (addr[3:2] decoded)
//   qout                  : registered read data
// Optional feature: define VIDEO_CAPTURE_CRC_EN to add a per-frame CRC in register 3.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int PIX_W    = 8,
    parameter int VADDR_W  = 20,
    parameter int XLEN     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vid_de,
    input  logic               vid_hsync,
    input  logic               vid_vsync,
    input  logic [PIX_W-1:0]   vid_data,
    output logic               vram_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [PIX_W-1:0]   vram_wdata,
    input  logic               sel,
    input  logic [XLEN-1:0]    addr,
    input  logic [2:0]         we,
    input  logic [XLEN-1:0]    qin,
    output logic [XLEN-1:0]    qout
);

    // x and y get one spare bit so overlong lines/frames stay distinguishable
    localparam int XW = $clog2(H_ACTIVE + 1) + 1;
    localparam int YW = $clog2(V_ACTIVE + 1) + 1;
    localparam logic [XW-1:0]      H_MAX  = XW'(H_ACTIVE);
    localparam logic [YW-1:0]      V_MAX  = YW'(V_ACTIVE);
    localparam logic [VADDR_W-1:0] H_STEP = VADDR_W'(H_ACTIVE);

    state_t state, state_nxt;

    logic               de_r, vs_r, de_q, vs_q;
    logic [PIX_W-1:0]   data_r;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [VADDR_W-1:0] addr_cnt, line_base;
    logic               cont, done, err_line, err_ovr;
    logic [15:0]        frame_cnt, crc_val;
    logic [XLEN-1:0]    rdata;
    logic               reg_wr, reg_rd, ctrl_wr, arm, clr;
    logic               de_fall, vs_fall, vs_rise, cap, ovr_px, wr_px, frame_end;
    logic               unused_ok;

    assign unused_ok = ^{vid_hsync, addr[XLEN-1:4], addr[1:0], qin[XLEN-1:3]};

    assign reg_wr  = sel && we != '0;
    assign reg_rd  = sel && we == '0;
    assign ctrl_wr = reg_wr && addr[3:2] == REG_CTRL;
    assign arm     = ctrl_wr && qin[CTRL_ARM];
    assign clr     = ctrl_wr && qin[CTRL_CLR];

    assign de_fall   = de_q && !de_r;
    assign vs_fall   = vs_q && !vs_r;
    assign vs_rise   = !vs_q && vs_r;
    assign cap       = state == CAPTURE;
    assign ovr_px    = cap && de_r && (x >= H_MAX || y >= V_MAX);
    assign wr_px     = cap && de_r && !ovr_px;
    assign frame_end = cap && vs_rise;

    always_comb begin
        state_nxt = state;
        if (state == IDLE && arm)
            state_nxt = WAIT_VS;
        else if (state == WAIT_VS && vs_fall)
            state_nxt = CAPTURE;
        else if (frame_end)
            state_nxt = cont ? WAIT_VS : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // input register plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_r   <= 1'b0;
            vs_r   <= 1'b0;
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            data_r <= '0;
        end else begin
            de_r   <= vid_de;
            vs_r   <= vid_vsync;
            de_q   <= de_r;
            vs_q   <= vs_r;
            data_r <= vid_data;
        end
    end

    // counters are held at zero outside CAPTURE, so every capture starts at 0;
    // at each line end the address realigns to the accumulated line base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            x          <= '0;
            y          <= '0;
            addr_cnt   <= '0;
            line_base  <= '0;
        end else begin
            vram_we <= wr_px;
            if (wr_px) begin
                vram_addr  <= addr_cnt;
                vram_wdata <= data_r;
            end
            if (!cap) begin
                x         <= '0;
                y         <= '0;
                addr_cnt  <= '0;
                line_base <= '0;
            end else if (de_fall) begin
                x         <= '0;
                y         <= y + YW'(y != '1);
                line_base <= line_base + H_STEP;
                addr_cnt  <= line_base + H_STEP;
            end else if (de_r) begin
                x        <= x + XW'(x != '1);
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // status events are applied after CLR so a same-cycle event wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont      <= 1'b0;
            done      <= 1'b0;
            err_line  <= 1'b0;
            err_ovr   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (ctrl_wr)
                cont <= qin[CTRL_CONT];
            if (clr) begin
                done      <= 1'b0;
                err_line  <= 1'b0;
                err_ovr   <= 1'b0;
                frame_cnt <= '0;
            end
            if (frame_end) begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (cap && de_fall && x != H_MAX)
                err_line <= 1'b1;
            if (ovr_px)
                err_ovr <= 1'b1;
        end
    end

`ifdef VIDEO_CAPTURE_CRC_EN
    video_capture_crc #(.PIX_W(PIX_W)) u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == WAIT_VS && vs_fall),
        .en    (wr_px),
        .data  (data_r),
        .crc   (crc_val)
    );
`else
    assign crc_val = '0;
`endif

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            REG_CTRL:   rdata[CTRL_CONT] = cont;
            REG_STATUS: begin
                rdata[ST_BUSY]     = state != IDLE;
                rdata[ST_DONE]     = done;
                rdata[ST_ERR_LINE] = err_line;
                rdata[ST_ERR_OVR]  = err_ovr;
            end
            REG_FCNT:   rdata[15:0] = frame_cnt;
            default:    rdata[15:0] = crc_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            qout <= '0;
        else if (reg_rd)
            qout <= rdata;
    end

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: randomized self-checking bench for video_capture (H=4, V=3)
module tb_video_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int PW = 8;
    localparam int AW = 20;
    localparam int XL = 32;

    logic          clk = 0, rst_n = 0;
    logic          vid_de = 0, vid_hsync = 0, vid_vsync = 0;
    logic [PW-1:0] vid_data = 0;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [PW-1:0] vram_wdata;
    logic          sel = 0;
    logic [XL-1:0] addr = 0, qin = 0, qout;
    logic [2:0]    we = 0;

    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct { int a; int d; int c; } wr_t;
    wr_t        exp_q[$];
    logic [7:0] crc_bytes[$];
    int         m_fcnt = 0;
    bit         m_done = 0, m_eline = 0, m_eovr = 0;

    video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .VADDR_W(AW), .XLEN(XL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vid_de     (vid_de),
        .vid_hsync  (vid_hsync),
        .vid_vsync  (vid_vsync),
        .vid_data   (vid_data),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .sel        (sel),
        .addr       (addr),
        .we         (we),
        .qin        (qin),
        .qout       (qout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // every VRAM write must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (rst_n && vram_we) begin
            check("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(vram_addr), e.a);
                check("wr_data", 32'(vram_wdata), e.d);
                check("wr_cycle", cyc, e.c);
            end
        end
    end

    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (crc_bytes[k]) begin
            c ^= {crc_bytes[k], 8'h00};
            repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input int a, input int d);
        tick();
        sel = 1; we = 3'b111; addr = XL'(a * 4); qin = XL'(d);
        tick();
        sel = 0; we = 0;
    endtask

    task automatic reg_read(input int a, output logic [31:0] rd);
        tick();
        sel = 1; we = 0; addr = XL'(a * 4);
        tick();
        sel = 0;
        rd = qout;
    endtask

    task automatic clear_all();
        reg_write(0, 4);
        m_done = 0; m_eline = 0; m_eovr = 0; m_fcnt = 0;
    endtask

    task automatic vs_pulse();
        tick(); vid_vsync = 1;
        tick(); tick(); vid_vsync = 0;
        tick(); tick();
    endtask

    // one line of len pixels; pixels inside the HxV window are expected at y*H+x
    task automatic send_line(input int l, input int len, input bit idx);
        for (int i = 0; i < len; i++) begin
            tick();
            vid_de = 1;
            vid_data = idx ? PW'(l * H + i) : PW'($urandom);
            if (l < V && i < H) begin
                exp_q.push_back('{l * H + i, int'(vid_data), cyc + 2});
                crc_bytes.push_back(vid_data);
            end else
                m_eovr = 1;
        end
        tick(); vid_de = 0; vid_hsync = 1;
        tick(); vid_hsync = 0;
        tick();
        if (len != H) m_eline = 1;
    endtask

    task automatic send_lines(input int nl, input int short_line, input bit idx);
        crc_bytes.delete();
        for (int l = 0; l < nl; l++) send_line(l, l == short_line ? H - 1 : H, idx);
    endtask

    task automatic end_frame();
        vs_pulse();
        m_done = 1;
        m_fcnt++;
        repeat (3) tick();
    endtask

    task automatic check_status(input string tag, input bit busy);
        logic [31:0] rd;
        reg_read(1, rd);
        check(tag, rd, {28'd0, m_eovr, m_eline, m_done, busy});
    endtask

    task automatic check_frame(input string tag);
        logic [31:0] rd;
        check({tag, "_q_empty"}, exp_q.size(), 0);
        reg_read(2, rd);
        check({tag, "_fcnt"}, rd, 32'(m_fcnt));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: no finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        repeat (3) tick();
        check("rst_we", 32'(vram_we), 0);
        check("rst_addr", 32'(vram_addr), 0);
        check("rst_wdata", 32'(vram_wdata), 0);
        check("rst_qout", qout, 0);
        rst_n = 1;
        tick();
        check_status("rst_status", 0);
        reg_read(2, rd); check("rst_fcnt", rd, 0);
        reg_read(3, rd); check("rst_crc", rd, 0);
        reg_read(0, rd); check("rst_ctrl", rd, 0);

        // single frame, pixel value = index
        reg_write(0, 1);
        vs_pulse();
        send_lines(3, -1, 1);
        end_frame();
        check_frame("single");
        check_status("single_status", 0);
        reg_read(3, rd);
`ifdef VIDEO_CAPTURE_CRC_EN
        check("single_crc", rd, 32'(ref_crc()));
`else
        check("single_crc_off", rd, 0);
`endif

        // continuous mode, three random frames; CONT dropped during the third
        clear_all();
        reg_write(0, 3);
        vs_pulse();
        send_lines(3, -1, 0);
        end_frame();
        send_lines(3, -1, 0);
        check_status("cont_busy", 1);
        end_frame();
        send_lines(3, -1, 0);
        check_status("cont_busy3", 1);
        reg_write(0, 0);
        end_frame();
        check_frame("cont");
        check_status("cont_status", 0);

        // short line 1: line 2 still starts at 2*H
        clear_all();
        check_status("clr_status", 0);
        reg_write(0, 1);
        vs_pulse();
        send_lines(3, 1, 0);
        end_frame();
        check_frame("short");
        check_status("short_status", 0);

        // extra fourth line: no writes past the window
        clear_all();
        reg_write(0, 1);
        vs_pulse();
        send_lines(4, -1, 0);
        end_frame();
        check_frame("ovr");
        check_status("ovr_status", 0);
        clear_all();
        check_status("ovr_clr_status", 0);
        reg_read(2, rd); check("ovr_clr_fcnt", rd, 0);

        // reset in the middle of line 1, then a clean re-armed frame
        reg_write(0, 1);
        vs_pulse();
        crc_bytes.delete();
        send_line(0, H, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vid_de = 1;
            vid_data = PW'($urandom);
            exp_q.push_back('{H + i, int'(vid_data), cyc + 2});
        end
        check("pre_rst_we", 32'(vram_we), 1);
        #2 rst_n = 0;
        #1 check("rst_async_we", 32'(vram_we), 0);
        exp_q.delete();
        vid_de = 0;
        m_done = 0; m_eline = 0; m_eovr = 0; m_fcnt = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        check_status("post_rst_status", 0);
        reg_write(0, 1);
        vs_pulse();
        send_lines(3, -1, 1);
        end_frame();
        check_frame("rearm");
        check_status("rearm_status", 0);
        reg_read(3, rd);
`ifdef VIDEO_CAPTURE_CRC_EN
        check("rearm_crc", rd, 32'(ref_crc()));
`else
        check("rearm_crc_off", rd, 0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
